// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone arbiter onto one shared slave bus.
// A master keeps the bus for as long as it holds CYC; there is no preemption.
// When both masters ask from IDLE, the one that was not the last owner wins.
// A watchdog ends a stalled strobe with ERR to the owner and a TMO_O pulse.
//
// Ports:
//   CLK_I, RST_I          clock, asynchronous active-low reset
//   Mn_*_I  (n = 0,1)     master request: ADR, DAT, WE, SEL, STB, CYC
//   Mn_DAT_O              read data (S_DAT_I broadcast to both masters)
//   Mn_ACK_O, Mn_ERR_O    termination, routed only to the current owner
//   S_*_O                 shared slave bus (all zero when idle)
//   S_DAT_I, S_ACK_I, S_ERR_I  slave response
//   GNT_O                 one-hot grant decoded from the state register (00 = idle)
//   TMO_O                 one-cycle pulse when the watchdog expires
module wb_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 8,
  parameter int unsigned SW      = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [AW-1:0] M0_ADR_I,
  input  logic [DW-1:0] M0_DAT_I,
  input  logic          M0_WE_I,
  input  logic [SW-1:0] M0_SEL_I,
  input  logic          M0_STB_I,
  input  logic          M0_CYC_I,
  output logic [DW-1:0] M0_DAT_O,
  output logic          M0_ACK_O,
  output logic          M0_ERR_O,
  input  logic [AW-1:0] M1_ADR_I,
  input  logic [DW-1:0] M1_DAT_I,
  input  logic          M1_WE_I,
  input  logic [SW-1:0] M1_SEL_I,
  input  logic          M1_STB_I,
  input  logic          M1_CYC_I,
  output logic [DW-1:0] M1_DAT_O,
  output logic          M1_ACK_O,
  output logic          M1_ERR_O,
  output logic [AW-1:0] S_ADR_O,
  output logic [DW-1:0] S_DAT_O,
  output logic          S_WE_O,
  output logic [SW-1:0] S_SEL_O,
  output logic          S_STB_O,
  output logic          S_CYC_O,
  input  logic [DW-1:0] S_DAT_I,
  input  logic          S_ACK_I,
  input  logic          S_ERR_I,
  output logic [1:0]    GNT_O,
  output logic          TMO_O
);

  // At least 8 bits, and always wide enough to hold TIMEOUT.
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = (TW > 8) ? TW : 8;

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] wdog_q, wdog_d;

  logic own0, own1, term, expire;

  assign own0 = (state_q == StOwn0);
  assign own1 = (state_q == StOwn1);
  assign term = S_ACK_I | S_ERR_I;

  // A real ACK/ERR in the expiry cycle takes precedence over the watchdog.
  assign expire = (TIMEOUT != 0) && S_STB_O && !term && (wdog_q == CW'(TIMEOUT));

  // Slave bus mux
  always_comb begin
    S_ADR_O = '0;
    S_DAT_O = '0;
    S_WE_O  = 1'b0;
    S_SEL_O = '0;
    S_STB_O = 1'b0;
    S_CYC_O = 1'b0;
    unique case (state_q)
      StOwn0: begin
        S_ADR_O = M0_ADR_I;
        S_DAT_O = M0_DAT_I;
        S_WE_O  = M0_WE_I;
        S_SEL_O = M0_SEL_I;
        S_STB_O = M0_STB_I;
        S_CYC_O = M0_CYC_I;
      end
      StOwn1: begin
        S_ADR_O = M1_ADR_I;
        S_DAT_O = M1_DAT_I;
        S_WE_O  = M1_WE_I;
        S_SEL_O = M1_SEL_I;
        S_STB_O = M1_STB_I;
        S_CYC_O = M1_CYC_I;
      end
      default: ;
    endcase
  end

  assign M0_DAT_O = S_DAT_I;
  assign M1_DAT_O = S_DAT_I;
  assign M0_ACK_O = S_ACK_I & ~S_ERR_I & M0_STB_I & own0;
  assign M1_ACK_O = S_ACK_I & ~S_ERR_I & M1_STB_I & own1;
  assign M0_ERR_O = (S_ERR_I | expire) & M0_STB_I & own0;
  assign M1_ERR_O = (S_ERR_I | expire) & M1_STB_I & own1;
  assign GNT_O    = {own1, own0};
  assign TMO_O    = expire;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (M0_CYC_I && M1_CYC_I) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (M0_CYC_I) begin
          state_d = StOwn0;
        end else if (M1_CYC_I) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!M0_CYC_I) begin
          state_d = M1_CYC_I ? StOwn1 : StIdle;
          last_d  = 1'b0;
        end
      end
      StOwn1: begin
        if (!M1_CYC_I) begin
          state_d = M0_CYC_I ? StOwn0 : StIdle;
          last_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Watchdog: counts stalled strobe cycles; held at zero when disabled.
  always_comb begin
    wdog_d = wdog_q + 1'b1;
    if ((TIMEOUT == 0) || (state_d != state_q) || !S_STB_O || term || expire) begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (TIMEOUT = 8).
module tb_wb_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 1;

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b0;
  logic [AW-1:0] M0_ADR_I = '0, M1_ADR_I = '0;
  logic [DW-1:0] M0_DAT_I = '0, M1_DAT_I = '0;
  logic          M0_WE_I = 1'b0, M1_WE_I = 1'b0;
  logic [SW-1:0] M0_SEL_I = '0, M1_SEL_I = '0;
  logic          M0_STB_I = 1'b0, M1_STB_I = 1'b0;
  logic          M0_CYC_I = 1'b0, M1_CYC_I = 1'b0;
  logic [DW-1:0] M0_DAT_O, M1_DAT_O;
  logic          M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O;
  logic [AW-1:0] S_ADR_O;
  logic [DW-1:0] S_DAT_O;
  logic          S_WE_O;
  logic [SW-1:0] S_SEL_O;
  logic          S_STB_O, S_CYC_O;
  logic [DW-1:0] S_DAT_I = '0;
  logic          S_ACK_I = 1'b0;
  logic          S_ERR_I = 1'b0;
  logic [1:0]    GNT_O;
  logic          TMO_O;

  wb_arbiter #(
    .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(8)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I), .M0_WE_I(M0_WE_I), .M0_SEL_I(M0_SEL_I),
    .M0_STB_I(M0_STB_I), .M0_CYC_I(M0_CYC_I), .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O),
    .M0_ERR_O(M0_ERR_O),
    .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I), .M1_WE_I(M1_WE_I), .M1_SEL_I(M1_SEL_I),
    .M1_STB_I(M1_STB_I), .M1_CYC_I(M1_CYC_I), .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O),
    .M1_ERR_O(M1_ERR_O),
    .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_WE_O(S_WE_O), .S_SEL_O(S_SEL_O),
    .S_STB_O(S_STB_O), .S_CYC_O(S_CYC_O), .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I),
    .S_ERR_I(S_ERR_I), .GNT_O(GNT_O), .TMO_O(TMO_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic [1:0]  gnt;
    logic [15:0] adr;
  } txn_t;

  txn_t        txn_q[$];   // expected service order: owner grant + address
  logic [2:0]  term_q[$];  // expected {TMO, ERR, ACK} per watchdog-test cycle
  int          checks = 0;
  int          failures = 0;
  int          served[2];
  int          rem[2];
  logic [15:0] madr[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  // Master n: off only drops CYC/STB so stale address/data stay on its inputs.
  task automatic drive_m(input int n, input logic on);
    if (n == 0) begin
      M0_CYC_I = on;
      M0_STB_I = on;
      if (on) begin
        M0_ADR_I = madr[0];
        M0_DAT_I = madr[0][7:0];
        M0_WE_I  = 1'b0;
        M0_SEL_I = 1'b1;
      end
    end else begin
      M1_CYC_I = on;
      M1_STB_I = on;
      if (on) begin
        M1_ADR_I = madr[1];
        M1_DAT_I = madr[1][7:0];
        M1_WE_I  = 1'b1;
        M1_SEL_I = 1'b0;
      end
    end
  endtask

  // Wait for a strobe on the slave bus, compare it against the scoreboard head,
  // acknowledge it, then let the owning master either keep CYC or release it.
  task automatic serve_one(input logic hold, input logic expect_nogap);
    int         n;
    int         who;
    txn_t       e;
    logic [7:0] d;
    n = 0;
    @(negedge CLK_I);
    while (!(S_CYC_O && S_STB_O) && n < 20) begin
      @(negedge CLK_I);
      n++;
    end
    chk("serve_wait_bound", 32'(n < 20), 32'd1);
    if (expect_nogap) chk("no_idle_gap", 32'(n), 32'd0);
    e   = txn_q.pop_front();
    who = (e.gnt == 2'b10) ? 1 : 0;
    chk("gnt", 32'(GNT_O), 32'(e.gnt));
    chk("s_adr", 32'(S_ADR_O), 32'(e.adr));
    chk("s_dat", 32'(S_DAT_O), 32'(e.adr[7:0]));
    chk("s_we", 32'(S_WE_O), 32'(who == 1));
    chk("s_sel", 32'(S_SEL_O), 32'(who == 0));
    d       = e.adr[7:0] ^ 8'hA5;
    S_DAT_I = d;
    S_ACK_I = 1'b1;
    #1;
    chk("m0_ack", 32'(M0_ACK_O), 32'(who == 0));
    chk("m1_ack", 32'(M1_ACK_O), 32'(who == 1));
    chk("m0_dat", 32'(M0_DAT_O), 32'(d));
    chk("m1_dat", 32'(M1_DAT_O), 32'(d));
    if (M0_ACK_O) served[0]++;
    if (M1_ACK_O) served[1]++;
    tick();
    S_ACK_I = 1'b0;
    madr[who]++;
    rem[who]--;
    if (hold && rem[who] > 0) begin
      drive_m(who, 1'b1);
    end else begin
      drive_m(who, 1'b0);
      tick();
      if (rem[who] > 0) drive_m(who, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [2:0] t;
    served[0] = 0;
    served[1] = 0;

    // Reset: bus must stay quiet even with a request and a slave ACK present.
    madr[0] = 16'h0100;
    drive_m(0, 1'b1);
    S_ACK_I = 1'b1;
    #2;
    chk("rst_gnt", 32'(GNT_O), 32'd0);
    chk("rst_s_cyc", 32'(S_CYC_O), 32'd0);
    chk("rst_m0_ack", 32'(M0_ACK_O), 32'd0);
    chk("rst_tmo", 32'(TMO_O), 32'd0);
    tick();
    tick();
    drive_m(0, 1'b0);
    S_ACK_I = 1'b0;
    RST_I   = 1'b1;

    // Simultaneous requests, then strict alternation, 6 transfers each.
    madr[0] = 16'h1000;
    madr[1] = 16'h2000;
    rem[0]  = 6;
    rem[1]  = 6;
    for (int i = 0; i < 6; i++) begin
      txn_q.push_back('{gnt: 2'b01, adr: 16'h1000 + 16'(i)});
      txn_q.push_back('{gnt: 2'b10, adr: 16'h2000 + 16'(i)});
    end
    drive_m(0, 1'b1);
    drive_m(1, 1'b1);
    @(negedge CLK_I);
    chk("latency_gnt", 32'(GNT_O), 32'd0);
    chk("latency_s_cyc", 32'(S_CYC_O), 32'd0);
    tick();
    for (int i = 0; i < 12; i++) serve_one(1'b0, 1'b1);
    chk("served_m0", 32'(served[0]), 32'd6);
    chk("served_m1", 32'(served[1]), 32'd6);
    chk("idle_gnt", 32'(GNT_O), 32'd0);
    chk("idle_s_adr", 32'(S_ADR_O), 32'd0);
    chk("idle_s_dat", 32'(S_DAT_O), 32'd0);
    chk("idle_s_we", 32'(S_WE_O), 32'd0);
    chk("idle_s_stb", 32'(S_STB_O), 32'd0);

    // M0 keeps CYC over 4 transfers while M1 waits: no preemption.
    madr[0] = 16'h3000;
    madr[1] = 16'h4000;
    rem[0]  = 4;
    rem[1]  = 1;
    for (int i = 0; i < 4; i++) txn_q.push_back('{gnt: 2'b01, adr: 16'h3000 + 16'(i)});
    txn_q.push_back('{gnt: 2'b10, adr: 16'h4000});
    drive_m(0, 1'b1);
    drive_m(1, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) serve_one(1'b1, 1'b1);
    serve_one(1'b0, 1'b1);
    chk("txn_q_drained", 32'(txn_q.size()), 32'd0);

    // Watchdog: expiry in stalled cycles 9 and 18; ACK wins in cycle 27;
    // ERR beats ACK in cycle 28.
    for (int c = 1; c <= 28; c++) begin
      term_q.push_back({1'(c == 9 || c == 18), 1'(c == 9 || c == 18 || c == 28), 1'(c == 27)});
    end
    madr[0] = 16'h5000;
    drive_m(0, 1'b1);
    tick();
    for (int c = 1; c <= 28; c++) begin
      S_ACK_I = (c == 27) || (c == 28);
      S_ERR_I = (c == 28);
      @(negedge CLK_I);
      t = term_q.pop_front();
      chk($sformatf("tmo_c%0d", c), 32'(TMO_O), 32'(t[2]));
      chk($sformatf("err_c%0d", c), 32'(M0_ERR_O), 32'(t[1]));
      chk($sformatf("ack_c%0d", c), 32'(M0_ACK_O), 32'(t[0]));
      tick();
    end
    S_ACK_I = 1'b0;
    S_ERR_I = 1'b0;
    drive_m(0, 1'b0);
    tick();

    // Reset in the middle of an M1 read.
    madr[1] = 16'h6000;
    drive_m(1, 1'b1);
    tick();
    chk("own1_gnt", 32'(GNT_O), 32'd2);
    chk("own1_s_cyc", 32'(S_CYC_O), 32'd1);
    madr[0] = 16'h7000;
    drive_m(0, 1'b1);
    tick();
    chk("own1_held", 32'(GNT_O), 32'd2);
    S_ACK_I = 1'b1;
    RST_I   = 1'b0;
    #1;
    chk("mid_rst_s_cyc", 32'(S_CYC_O), 32'd0);
    chk("mid_rst_s_stb", 32'(S_STB_O), 32'd0);
    chk("mid_rst_gnt", 32'(GNT_O), 32'd0);
    chk("mid_rst_m1_ack", 32'(M1_ACK_O), 32'd0);
    tick();
    S_ACK_I = 1'b0;
    #3;
    RST_I = 1'b1;
    #1;
    chk("post_rst_wait", 32'(GNT_O), 32'd0);
    tick();
    chk("post_rst_tie", 32'(GNT_O), 32'd1);
    chk("post_rst_adr", 32'(S_ADR_O), 32'h7000);
    drive_m(0, 1'b0);
    drive_m(1, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter AW, default 16, address width.
REQ-002 Parameter DW, default 8, data width.
REQ-003 Parameter SW, default 1, select width.
REQ-004 Parameter TIMEOUT, default 255, cycles without slave termination before forced error; 0 disables the watchdog.
REQ-005 CLK_I  in  1  single clock; all state updates on rising edge.
REQ-006 RST_I  in  1  asynchronous, active-low reset.
REQ-007 Mn_ADR_I/Mn_DAT_I/Mn_WE_I/Mn_SEL_I/Mn_STB_I/Mn_CYC_I  in  AW/DW/1/SW/1/1  Wishbone master n port, n = 0,1.
REQ-008 Mn_DAT_O  out  DW  read data to master n.
REQ-009 Mn_ACK_O/Mn_ERR_O  out  1  termination to master n.
REQ-010 S_ADR_O/S_DAT_O/S_WE_O/S_SEL_O/S_STB_O/S_CYC_O  out  AW/DW/1/SW/1/1  shared slave bus.
REQ-011 S_DAT_I/S_ACK_I/S_ERR_I  in  DW/1/1  slave response.
REQ-012 GNT_O  out  2  one-hot registered grant (bit n = master n); 00 when idle.
REQ-013 TMO_O  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-014 The arbiter SHALL have states IDLE, OWN0, OWN1; GNT_O = 00/01/10 respectively.
REQ-015 IDLE: if exactly one Mn_CYC_I=1, next state OWNn; if both, next state OWN of the master not in register LAST; if none, stay IDLE.
REQ-016 Grant latency SHALL be one cycle: request sampled at edge k, S_CYC_O valid after edge k.
REQ-017 OWNn SHALL be held while Mn_CYC_I=1, regardless of the other master's requests (no preemption).
REQ-018 OWNn with Mn_CYC_I=0: next state OWNm (m≠n) if Mm_CYC_I=1, else IDLE; LAST := n on this edge.
REQ-019 In OWNn, S_ADR_O, S_DAT_O, S_WE_O, S_SEL_O, S_STB_O, S_CYC_O SHALL combinationally equal master n's inputs.
REQ-020 In IDLE, S_CYC_O=S_STB_O=S_WE_O=0, S_ADR_O/S_DAT_O/S_SEL_O=0.
REQ-021 Mn_DAT_O SHALL equal S_DAT_I for both masters (broadcast).
REQ-022 Mn_ACK_O = S_ACK_I & ~S_ERR_I & Mn_STB_I & OWNn; non-owner ACK/ERR SHALL be 0.
REQ-023 Mn_ERR_O = (S_ERR_I | watchdog expiry) & Mn_STB_I & OWNn; S_ERR_I has priority over S_ACK_I.
REQ-024 Watchdog counter (8+ bits, width ≥ log2(TIMEOUT+1)) SHALL increment each cycle S_STB_O=1 and S_ACK_I=S_ERR_I=0, and clear when S_STB_O=0, on any ACK/ERR, on state change, or on expiry.
REQ-025 Expiry SHALL occur in the cycle the counter equals TIMEOUT (TIMEOUT≠0) and no ACK/ERR is present; TMO_O=1 that cycle only.
REQ-026 ACK or ERR arriving in the expiry cycle SHALL win: normal termination, TMO_O=0.
REQ-027 Counter SHALL saturate-free wrap never occur: expiry clears it before overflow.

Reset
REQ-028 RST_I=0 SHALL immediately force state IDLE, GNT_O=00, LAST=1 (master 0 wins first tie), watchdog=0, TMO_O=0.
REQ-029 Reset mid-transfer SHALL drop S_CYC_O/S_STB_O in the same cycle; no ACK/ERR propagated while RST_I=0.
REQ-030 After RST_I rises, first arbitration SHALL occur on the next rising edge.

Verification
REQ-031 Both CYC raised same cycle after reset -> GNT_O=01 next cycle; M0 drops CYC -> GNT_O=10 next cycle with no IDLE gap.
REQ-032 M0 holds CYC over 4 transfers while M1 requests -> GNT_O stays 01; each S_ACK_I pulse seen only on M0_ACK_O; M1_ACK_O=0.
REQ-033 Alternating contention, 6 transactions each -> grants alternate 01,10,01,...; each master served exactly 6 times.
REQ-034 TIMEOUT=8, slave never acks -> M0_ERR_O and TMO_O high exactly in the 9th STB cycle, counter restarts at 0.
REQ-035 S_ACK_I and S_ERR_I both high -> M0_ERR_O=1, M0_ACK_O=0; S_ACK_I on expiry cycle -> ACK, TMO_O=0.
REQ-036 RST_I low during OWN1 read -> S_CYC_O=0 and GNT_O=00 same cycle; after release, tie -> GNT_O=01.
